// File: rtl/seq_pkg.sv
// Shared types for the hex digit sequencer: digit entry layout and sequencer states.
package seq_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef struct packed {
    logic               dp;
    logic [DIGIT_W-1:0] nib;
  } digit_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StGap
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running digit-rate prescaler; emits a one-cycle tick every max(period,1) enabled clocks.
module tick_prescaler #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit;

  always_comb begin
    limit  = (period_i == '0) ? '0 : period_i - CNT_W'(1);
    // >= so that shrinking the period below the current count fires at once
    tick_o = en_i && (cnt_q >= limit);
    cnt_d  = cnt_q + CNT_W'(1);
    if (!en_i || clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_digit_sequencer.sv
// Digit buffer and read pointer feeding the seven-segment decoder.
// Define SEQ_BLANK_GAP_EN to insert a blanked gap period between auto-advanced digits.
module hex_digit_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [4:0]        wr_data_i,
  input  logic              last_wr_en_i,
  input  logic [ADDR_W-1:0] last_in_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic              run_i,
  input  logic              step_i,
  output logic [3:0]        hex_o,
  output logic              dp_o,
  output logic              blank_o,
  output logic [ADDR_W-1:0] digit_idx_o,
  output logic              wrap_o
);

  digit_t            mem_q [DEPTH];
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q;
  state_e            state_q, state_d;
  digit_t            out_q, out_d;
  logic              blank_q, blank_d;
  logic              wrap_q, wrap_d;
  logic              tick, adv, at_end;

  tick_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (state_q != StIdle),
    .clr_i    (step_i),
    .period_i (period_i),
    .tick_o   (tick)
  );

  always_comb begin
    state_d = run_i ? StRun : StIdle;
    blank_d = 1'b0;
`ifdef SEQ_BLANK_GAP_EN
    adv = step_i;
    unique case (state_q)
      StRun: begin
        if (run_i && tick && !step_i) begin
          state_d = StGap;
          blank_d = 1'b1;
        end
      end
      StGap: begin
        if (run_i) begin
          if (tick || step_i) begin
            adv = 1'b1;
          end else begin
            state_d = StGap;
            blank_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
`else
    adv = tick | step_i;
`endif
    // >= also catches last being lowered below the current pointer
    at_end = (ptr_q >= last_q);
    ptr_d  = ptr_q;
    wrap_d = 1'b0;
    if (adv) begin
      wrap_d = at_end;
      ptr_d  = at_end ? '0 : ptr_q + ADDR_W'(1);
    end
    out_d = (wr_en_i && (wr_addr_i == ptr_d)) ? digit_t'(wr_data_i) : mem_q[ptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      last_q  <= ADDR_W'(DEPTH - 1);
      state_q <= StIdle;
      ptr_q   <= '0;
      out_q   <= '0;
      blank_q <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_addr_i] <= digit_t'(wr_data_i);
      end
      if (last_wr_en_i) begin
        last_q <= last_in_i;
      end
      state_q <= state_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      blank_q <= blank_d;
      wrap_q  <= wrap_d;
    end
  end

  assign hex_o       = out_q.nib;
  assign dp_o        = out_q.dp;
  assign blank_o     = blank_q;
  assign digit_idx_o = ptr_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_hex_digit_sequencer.sv
// Scoreboard bench for hex_digit_sequencer: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_hex_digit_sequencer;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [4:0]        wr_data;
  logic              last_wr_en;
  logic [ADDR_W-1:0] last_in;
  logic [CNT_W-1:0]  period;
  logic              run;
  logic              step;
  logic [3:0]        hex;
  logic              dp;
  logic              blank;
  logic [ADDR_W-1:0] digit_idx;
  logic              wrap;

  always #5 clk = ~clk;

  hex_digit_sequencer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .last_wr_en_i (last_wr_en),
    .last_in_i    (last_in),
    .period_i     (period),
    .run_i        (run),
    .step_i       (step),
    .hex_o        (hex),
    .dp_o         (dp),
    .blank_o      (blank),
    .digit_idx_o  (digit_idx),
    .wrap_o       (wrap)
  );

  typedef struct {
    int unsigned       cyc;
    string             name;
    logic [3:0]        hex;
    logic              dp;
    logic              blank;
    logic [ADDR_W-1:0] idx;
    logic              wrap;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc_cnt = 0;
  int unsigned checks  = 0;
  int unsigned errors  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc_cnt) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc_cnt) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc_cnt);
      end else if ({hex, dp, blank, digit_idx, wrap} !== {e.hex, e.dp, e.blank, e.idx, e.wrap}) begin
        errors++;
        $display("FAIL %s @%0d: got hex=%h dp=%b blank=%b idx=%0d wrap=%b, want hex=%h dp=%b blank=%b idx=%0d wrap=%b",
                 e.name, cyc_cnt, hex, dp, blank, digit_idx, wrap,
                 e.hex, e.dp, e.blank, e.idx, e.wrap);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // dly=0 checks the current cycle; dly=1 the result of inputs driven now.
  task automatic expect_out(input int unsigned dly, input string name, input int h, input int d,
                            input int b, input int i, input int w);
    exp_t        e;
    int unsigned k;
    e.cyc   = cyc_cnt + dly;
    e.name  = name;
    e.hex   = 4'(h);
    e.dp    = 1'(d);
    e.blank = 1'(b);
    e.idx   = ADDR_W'(i);
    e.wrap  = 1'(w);
    k = 0;
    while (k < sb.size() && sb[k].cyc <= e.cyc) k++;
    sb.insert(k, e);
  endtask

  task automatic step_and_expect(input string name, input int h, input int d, input int i,
                                 input int w);
    step = 1'b1;
    expect_out(1, name, h, d, 0, i, w);
    cycle();
    step = 1'b0;
    cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation ran past time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; last_wr_en = 1'b0;
    last_in = '0; period = '0; run = 1'b0; step = 1'b0;
    repeat (2) cycle();
    expect_out(0, "reset", 0, 0, 1, 0, 0);
    rst_n = 1'b1;
    expect_out(1, "blank_release", 0, 0, 0, 0, 0);
    cycle();

    // Load 1,2,3,4 then auto-run at period 4
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = 5'(i + 1);
      cycle();
    end
    wr_en = 1'b0; last_wr_en = 1'b1; last_in = 3; period = 4;
    expect_out(0, "entry0_loaded", 1, 0, 0, 0, 0);
    cycle();
    last_wr_en = 1'b0; run = 1'b1;
    expect_out(4,  "run_hold0",  1, 0, 0, 0, 0);
    expect_out(5,  "run_adv1",   2, 0, 0, 1, 0);
    expect_out(8,  "run_hold1",  2, 0, 0, 1, 0);
    expect_out(9,  "run_adv2",   3, 0, 0, 2, 0);
    expect_out(13, "run_adv3",   4, 0, 0, 3, 0);
    expect_out(16, "run_hold3",  4, 0, 0, 3, 0);
    expect_out(17, "run_wrap",   1, 0, 0, 0, 1);
    expect_out(18, "wrap_pulse", 1, 0, 0, 0, 0);
    repeat (18) cycle();
    run = 1'b0;
    repeat (2) cycle();

    // Manual steps in IDLE, then no auto-advance
    for (int s = 1; s <= 3; s++) step_and_expect("manual_step", s + 1, 0, s, 0);
    expect_out(50,  "idle_hold50",  4, 0, 0, 3, 0);
    expect_out(100, "idle_hold100", 4, 0, 0, 3, 0);
    repeat (100) cycle();

    // Step wrap, then walk to entry 2 and write through
    step_and_expect("step_wrap", 1, 0, 0, 1);
    expect_out(0, "wrap_one_cycle", 1, 0, 0, 0, 0);
    step_and_expect("step_to1", 2, 0, 1, 0);
    step_and_expect("step_to2", 3, 0, 2, 0);
    wr_en = 1'b1; wr_addr = 2; wr_data = 5'h1A;
    expect_out(1, "write_through", 4'hA, 1, 0, 2, 0);
    cycle();
    wr_addr = 5; wr_data = 5'h07;
    expect_out(1, "write_other", 4'hA, 1, 0, 2, 0);
    cycle();
    wr_en = 1'b0;

    // period=0, last=1: advance every cycle, wrap every second
    last_wr_en = 1'b1; last_in = 1; period = 0;
    cycle();
    last_wr_en = 1'b0; run = 1'b1;
    expect_out(1, "p0_enter",  4'hA, 1, 0, 2, 0);
    expect_out(2, "p0_wrap_a", 1, 0, 0, 0, 1);
    expect_out(3, "p0_one_a",  2, 0, 0, 1, 0);
    expect_out(4, "p0_wrap_b", 1, 0, 0, 0, 1);
    expect_out(5, "p0_one_b",  2, 0, 0, 1, 0);
    repeat (5) cycle();
    run = 1'b0;
    repeat (2) cycle();

    // last=7, walk to 5, lower last to 2, next step wraps
    last_wr_en = 1'b1; last_in = 7;
    cycle();
    last_wr_en = 1'b0;
    step_and_expect("walk1", 2, 0, 1, 0);
    step_and_expect("walk2", 4'hA, 1, 2, 0);
    step_and_expect("walk3", 4, 0, 3, 0);
    step_and_expect("walk4", 0, 0, 4, 0);
    step_and_expect("walk5", 7, 0, 5, 0);
    last_wr_en = 1'b1; last_in = 2;
    cycle();
    last_wr_en = 1'b0;
    step_and_expect("lowered_last_wrap", 1, 0, 0, 1);
    expect_out(0, "lowered_wrap_clear", 1, 0, 0, 0, 0);

    // Step during RUN restarts the prescaler
    last_wr_en = 1'b1; last_in = 7; period = 4;
    cycle();
    last_wr_en = 1'b0; run = 1'b1;
    expect_out(5,  "tick_adv",      2, 0, 0, 1, 0);
    expect_out(8,  "run_step",      4'hA, 1, 0, 2, 0);
    expect_out(11, "no_early_tick", 4'hA, 1, 0, 2, 0);
    expect_out(12, "full_period",   4, 0, 0, 3, 0);
    repeat (7) cycle();
    step = 1'b1;
    cycle();
    step = 1'b0;
    repeat (5) cycle();
    run = 1'b0;
    cycle();

    // Reset mid-run clears outputs and buffer
    period = 1; run = 1'b1;
    repeat (3) cycle();
    rst_n = 1'b0; run = 1'b0;
    expect_out(1, "mid_reset", 0, 0, 1, 0, 0);
    cycle();
    rst_n = 1'b1;
    expect_out(1, "post_reset", 0, 0, 0, 0, 0);
    cycle();
    for (int i = 1; i < 8; i++) step_and_expect("cleared_entry", 0, 0, i, 0);
    step_and_expect("cleared_wrap", 0, 0, 0, 1);

    for (int n = 0; n < 200 && sb.size() != 0; n++) cycle();
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations never compared", sb.size());
      errors += sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
